// File: rtl/elastic_pipe_stage.sv
// Elastic inter-stage pipeline buffer: DEPTH-entry circular FIFO with valid/allow
// interlock, ready_go stall, synchronous flush and an optional hold-last-value output.
module elastic_pipe_stage #(
  parameter int               WIDTH         = 32,
  parameter int               DEPTH         = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
  parameter bit               REG_ALLOW     = 1'b0,
  parameter bit               HOLD_ON_EMPTY = 1'b0
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       valid_in,
  input  logic [WIDTH-1:0]           data_in,
  output logic                       allow_out,
  input  logic                       ready_go,
  input  logic                       allow_in,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           nop_data,
  output logic                       valid_out,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 1 || DEPTH > 16) begin : g_depth_chk
    $fatal(1, "elastic_pipe_stage: DEPTH must be in 1..16");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             push, pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign valid_out = !empty && ready_go;
  assign pop       = valid_out && allow_in;
  assign push      = valid_in && allow_out;

  // Registered mode looks only at occupancy so allow never ripples upstream.
  if (REG_ALLOW) begin : g_reg_allow
    assign allow_out = !full;
  end else begin : g_comb_allow
    assign allow_out = !full || pop;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    hold_d   = hold_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        hold_d   = mem_q[rd_ptr_q];
      end
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_comb begin
    data_out = nop_data;
    if (!empty)             data_out = mem_q[rd_ptr_q];
    else if (HOLD_ON_EMPTY) data_out = hold_q;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= RESET_VALUE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge aclk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: doc/elastic_pipe_stage.md
Name: elastic_pipe_stage

Overview:
Parametrised inter-stage pipeline buffer for the CPU pipeline. It uses the same valid/allow interlock, ready_go stall and flush semantics as the single-entry stage register. Storage is generalised to a DEPTH-entry circular buffer, with an optional registered allow path to break the combinational allow chain, and an optional hold-last-value output mode for PC-like stages. It sits between any two pipeline stages; DEPTH=1 with REG_ALLOW=0 is cycle-equivalent to the existing stage register.

Parameters:
WIDTH, 32, payload width in bits (data_in/data_out/nop_data).
DEPTH, 2, number of buffered entries; legal range 1..16, non-power-of-2 allowed.
RESET_VALUE, 0, value loaded into the hold register at reset.
REG_ALLOW, 0, 0: allow_out depends combinationally on allow_in; 1: allow_out = !full only.
HOLD_ON_EMPTY, 0, 0: data_out = nop_data when empty; 1: data_out = last popped entry when empty.

Ports:
aclk  input  1  clock, all state on rising edge
aresetn  input  1  asynchronous active-low reset
valid_in  input  1  upstream offers data_in this cycle
data_in  input  WIDTH  upstream payload
allow_out  output  1  stage accepts data_in this cycle
ready_go  input  1  head entry has finished this stage's work; 0 stalls output
allow_in  input  1  downstream accepts data_out this cycle
flush  input  1  synchronous kill of all buffered entries
nop_data  input  WIDTH  payload presented when empty (HOLD_ON_EMPTY=0)
valid_out  output  1  head entry offered downstream
data_out  output  WIDTH  head payload / nop / hold value
count  output  $clog2(DEPTH+1)  current occupancy
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
- Definitions: push = valid_in && allow_out; pop = valid_out && allow_in; valid_out = !empty && ready_go.
- allow_out: REG_ALLOW=0 -> !full || (valid_out && allow_in); REG_ALLOW=1 -> !full.
- Latency: minimum 1 cycle. No fall-through; an entry pushed at edge t is visible on valid_out after edge t.
- Order: strict FIFO. wr_ptr/rd_ptr advance on push/pop, wrap DEPTH-1 -> 0.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push+pop when full: legal only with REG_ALLOW=0; count stays DEPTH, head advances, new entry written into the freed slot.
- Simultaneous push+pop when empty: impossible (valid_out=0 when empty).
- ready_go=0: valid_out=0, no pop. Pushes continue while !full. Head data_out stays driven.
- flush=1 (priority over push/pop): next edge count=0 and pointers=0. The same-cycle push is discarded and the same-cycle pop is not counted as delivered. The hold register is NOT changed by flush.
- data_out (combinational):
  - !empty -> mem[rd_ptr], independent of ready_go.
  - empty && HOLD_ON_EMPTY=1 -> hold_reg.
  - empty && HOLD_ON_EMPTY=0 -> nop_data.
- hold_reg loads mem[rd_ptr] on every pop.
- Reset (aresetn low, asynchronous, any time incl. mid-transfer): count=0, pointers=0, hold_reg=RESET_VALUE. Resulting outputs: valid_out=0, empty=1, full=0, data_out = nop_data or RESET_VALUE per mode. allow_out=1 on the first edge after deassert. Storage array is not reset.
- Misuse: flush and ready_go must not be held constant-asserted/deasserted forever by the instantiating stage; the block does not guard against deadlock.
- Elaboration: DEPTH<1 or DEPTH>16 is a fatal error.

Test Plan:
- DEPTH=1, REG_ALLOW=0, allow_in=1, ready_go=1: push 0xA,0xB,0xC back-to-back -> valid_out high from cycle 2, data_out 0xA,0xB,0xC consecutive, allow_out constantly 1.
- DEPTH=3, REG_ALLOW=1, allow_in=0: push 0x1..0x4 -> count 1,2,3, full=1 and allow_out=0 at count 3, 0x4 held upstream. Release allow_in -> pops 0x1,0x2,0x3 then 0x4 in order, pointer wrap exercised.
- DEPTH=2 full, REG_ALLOW=0, allow_in=1, valid_in=1: push+pop same cycle -> count stays 2, allow_out=1. Compare with REG_ALLOW=1: allow_out=0.
- DEPTH=2 holding 0x5,0x6, flush=1 with valid_in=1/data_in=0x7 -> next cycle count=0, valid_out=0, data_out=nop_data, 0x7 never emerges.
- HOLD_ON_EMPTY=1, RESET_VALUE=0x1C000000: after reset data_out=0x1C000000. Pop 0x1C000004 -> empty, data_out=0x1C000004. Flush -> still 0x1C000004.
- Assert aresetn=0 mid-stream (count=2, no clock edge) -> count=0, valid_out=0 immediately. ready_go=0 with data buffered -> valid_out=0, data_out shows head, count unchanged.
